// File: rtl/flash_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : flash_mem_responder_if
// Description : Avalon-MM read-only bus between a master and flash_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface flash_mem_responder_if;
   logic        flash_mem_read;
   logic [22:0] flash_mem_address;
   logic [3:0]  flash_mem_byteenable;
   logic        flash_mem_waitrequest;
   logic [31:0] flash_mem_readdata;
   logic        flash_mem_readdatavalid;

   modport master (
      output flash_mem_read,
      output flash_mem_address,
      output flash_mem_byteenable,
      input  flash_mem_waitrequest,
      input  flash_mem_readdata,
      input  flash_mem_readdatavalid
   );

   modport slave (
      input  flash_mem_read,
      input  flash_mem_address,
      input  flash_mem_byteenable,
      output flash_mem_waitrequest,
      output flash_mem_readdata,
      output flash_mem_readdatavalid
   );
endinterface
`default_nettype wire

// File: rtl/flash_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : flash_mem_responder
// Description : Avalon-MM read responder emulating a flash with wait states
//               in front of a fixed-latency backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_mem_responder #(
   parameter logic [22:0] MAX_ADDR    = 23'h7FFFF,
   parameter int          WAIT_STATES = 2,
   parameter int          MEM_LATENCY = 1
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   flash_mem_responder_if.slave bus,
   output logic             mem_rd,
   output logic [22:0]      mem_addr,
   input  wire logic [31:0] mem_rdata,
   output logic             err_range
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      FETCH = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] c_ws_load   = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
   localparam logic [3:0] c_lat_load  = 4'(MEM_LATENCY - 1);
   localparam bit         c_zero_wait = (WAIT_STATES == 0);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [22:0] r_addr;
   logic [3:0]  r_be;
   logic        r_oor;
   logic [31:0] r_rdata;

   logic        w_latch;
   logic        w_accept;
   logic        w_wait;
   logic        w_capture;
   logic        w_addr_oor;
   logic        w_oor;
   logic [22:0] w_acc_addr;
   logic [31:0] w_lane_mask;

   // With zero wait states the accept happens in IDLE, before anything is latched.
   assign w_addr_oor  = (bus.flash_mem_address > MAX_ADDR);
   assign w_oor       = (r_state == IDLE) ? w_addr_oor : r_oor;
   assign w_acc_addr  = (r_state == IDLE) ? bus.flash_mem_address : r_addr;
   assign w_lane_mask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_accept    = 1'b0;
      w_wait      = 1'b1;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.flash_mem_read) begin
               w_latch = 1'b1;
               if (c_zero_wait) begin
                  w_wait      = 1'b0;
                  w_accept    = 1'b1;
                  w_cnt_nxt   = c_lat_load;
                  w_state_nxt = FETCH;
               end else begin
                  w_cnt_nxt   = c_ws_load;
                  w_state_nxt = STALL;
               end
            end else begin
               w_wait = 1'b0;
            end
         end
         STALL: begin
            if (!bus.flash_mem_read) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = IDLE;
            end else if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_wait      = 1'b0;
               w_accept    = 1'b1;
               w_cnt_nxt   = c_lat_load;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 23'd0;
         r_be    <= 4'd0;
         r_oor   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_addr <= bus.flash_mem_address;
            r_be   <= bus.flash_mem_byteenable;
            r_oor  <= w_addr_oor;
         end
         // Out-of-range reads return erased flash, still subject to lane masking.
         if (w_capture) begin
            r_rdata <= (r_oor ? 32'hFFFF_FFFF : mem_rdata) & w_lane_mask;
         end
      end
   end

   // Reset gates the combinational outputs so they settle immediately.
   assign mem_rd    = reset_n & w_accept & ~w_oor;
   assign err_range = reset_n & w_accept & w_oor;
   assign mem_addr  = mem_rd ? w_acc_addr : r_addr;

   assign bus.flash_mem_waitrequest   = ~reset_n | w_wait;
   assign bus.flash_mem_readdata      = r_rdata;
   assign bus.flash_mem_readdatavalid = (r_state == RESP);

endmodule
`default_nettype wire

// File: doc/flash_mem_responder.md
FLASH_MEM_RESPONDER -- requirements
Module: flash_mem_responder

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 23'h7FFFF: highest valid word address.
REQ-002 SHALL have parameter WAIT_STATES, default 2: waitrequest-high cycles before a read is accepted; legal range 0-15.
REQ-003 SHALL have parameter MEM_LATENCY, default 1: cycles from mem_rd to valid mem_rdata; legal range 1-4.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port flash_mem_read  in  1  read request from the Avalon-MM master.
REQ-007 SHALL have port flash_mem_address  in  23  word address; master holds it stable while waitrequest is high.
REQ-008 SHALL have port flash_mem_byteenable  in  4  byte-lane enables for the read.
REQ-009 SHALL have port flash_mem_waitrequest  out  1  high = command not accepted this cycle.
REQ-010 SHALL have port flash_mem_readdata  out  32  response word.
REQ-011 SHALL have port flash_mem_readdatavalid  out  1  one-cycle strobe qualifying readdata.
REQ-012 SHALL have port mem_rd  out  1  one-cycle read strobe to the backing memory.
REQ-013 SHALL have port mem_addr  out  23  backing-memory word address.
REQ-014 SHALL have port mem_rdata  in  32  backing-memory data, valid MEM_LATENCY cycles after mem_rd.
REQ-015 SHALL have port err_range  out  1  one-cycle pulse on an accepted out-of-range read.

Function
REQ-016 SHALL implement the FSM states IDLE, STALL, FETCH and RESP, with at most one read outstanding.
REQ-017 IDLE: when read=1 and WAIT_STATES>0, SHALL latch address/byteenable, drive waitrequest=1, load the stall counter with WAIT_STATES-1 and go to STALL.
REQ-018 IDLE: when read=1 and WAIT_STATES=0, SHALL drive waitrequest=0 combinationally and accept that same cycle.
REQ-019 STALL: SHALL drive waitrequest=1 while the counter is nonzero and decrement it; at counter=0 SHALL drive waitrequest=0 (accept cycle) and go to FETCH.
REQ-020 Accept cycle: SHALL pulse mem_rd with mem_addr equal to the latched address, unless the address exceeds MAX_ADDR.
REQ-021 Out-of-range accept (address > MAX_ADDR): SHALL NOT pulse mem_rd, SHALL pulse err_range in the accept cycle, and the response data SHALL be 32'hFFFFFFFF (erased flash).
REQ-022 FETCH: SHALL hold waitrequest=1 for MEM_LATENCY cycles, then register mem_rdata (or 32'hFFFFFFFF if out of range) and go to RESP.
REQ-023 Byte lanes with byteenable=0 SHALL read 8'h00 in readdata.
REQ-024 RESP: SHALL assert readdatavalid for exactly one cycle with readdata valid, hold waitrequest=1, then go to IDLE.
REQ-025 readdata SHALL hold its last value when readdatavalid=0.
REQ-026 Latency rule: read first seen at cycle n SHALL be accepted at cycle n+WAIT_STATES, with readdatavalid at cycle n+WAIT_STATES+MEM_LATENCY+1.
REQ-027 A read asserted during FETCH or RESP SHALL see waitrequest=1 and SHALL be serviced starting from the next IDLE cycle.
REQ-028 If read deasserts during STALL, the block SHALL abort to IDLE with no mem_rd, readdatavalid or err_range.
REQ-029 Address MAX_ADDR SHALL be treated as valid; MAX_ADDR+1 and above SHALL be treated as out of range.
REQ-030 Outside the accept cycle, waitrequest SHALL be 1 except in IDLE with read=0, where it SHALL be 0.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, counter 0, waitrequest 1, readdatavalid 0, readdata 0, mem_rd 0, mem_addr 0 and err_range 0.
REQ-032 A reset mid-transaction SHALL discard the transaction; no readdatavalid SHALL follow the deassertion of reset.
REQ-033 After reset_n rises, the first read SHALL be serviced per REQ-026.

Verification
REQ-034 WAIT_STATES=2, MEM_LATENCY=1, read addr 23'h00010 at cycle 0, mem_rdata 32'hA5A5_1234 -> waitrequest=1 at cycles 0-1 and 0 at cycle 2; mem_rd at cycle 2; readdatavalid at cycle 4 with readdata 32'hA5A5_1234.
REQ-035 byteenable 4'b0101 with mem_rdata 32'h1122_3344 -> readdata 32'h0022_0044.
REQ-036 Read addr 23'h7FFFF -> mem_rd pulses, normal data; read addr 23'h80000 -> no mem_rd, err_range pulses, readdata 32'hFFFFFFFF.
REQ-037 Read held high continuously across two transactions -> second accept occurs no earlier than the IDLE cycle after RESP; exactly two readdatavalid pulses.
REQ-038 reset_n=0 asserted during FETCH -> outputs match REQ-031 within the same cycle; no readdatavalid after release.
REQ-039 WAIT_STATES=0, MEM_LATENCY=3: read at cycle 0 -> waitrequest=0 at cycle 0, readdatavalid at cycle 4.
